// File: rtl/port_arbiter_pkg.sv
// Shared widths, state codes and the latched transaction payload for port_arbiter.
package port_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 3;

    // Arbiter FSM state codes
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // One master transaction as latched at grant time
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } port_txn_t;

endpackage

// File: rtl/port_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to
// the master that did not win last time.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_c,
    output logic       any_c
);

    // Grant selection
    always_comb begin
        any_c   = |req;
        grant_c = 1'b0;
        if (req == 2'b11) begin
            grant_c = ~last_grant;
        end else begin
            grant_c = req[1];
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Shares the single I/O port bus between m0 (CPU) and m1 (debug monitor).
// One transaction at a time, registered strobes, read data captured after a
// fixed device latency and returned with a one-cycle ack.
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              port_read,
    output logic              port_write,
    output logic [ADDR_W-1:0] port_addr,
    output logic [DATA_W-1:0] port_write_data,
    input  logic [DATA_W-1:0] port_read_data
);

    arb_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    port_txn_t         txn, txn_next, pick;
    logic              owner, owner_next;
    logic              last_grant, last_grant_next;
    logic              grant, req_any;

    logic              port_read_next, port_write_next;
    logic [ADDR_W-1:0] port_addr_next;
    logic [DATA_W-1:0] port_write_data_next;
    logic              m0_ack_next, m1_ack_next;
    logic [DATA_W-1:0] m0_rdata_next, m1_rdata_next;

    rr_arbiter_2 u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .grant_c    (grant),
        .any_c      (req_any)
    );

    // Payload of whichever master the round-robin pick selects
    always_comb begin
        pick = '0;
        if (grant) begin
            pick = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
        end else begin
            pick = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_next           = state;
        cnt_next             = cnt;
        txn_next             = txn;
        owner_next           = owner;
        last_grant_next      = last_grant;
        port_read_next       = 1'b0;
        port_write_next      = 1'b0;
        port_addr_next       = '0;
        port_write_data_next = '0;
        m0_ack_next          = 1'b0;
        m1_ack_next          = 1'b0;
        m0_rdata_next        = m0_rdata;
        m1_rdata_next        = m1_rdata;

        case (state)
            ARB_IDLE: begin
                if (req_any) begin
                    owner_next           = grant;
                    last_grant_next      = grant;
                    txn_next             = pick;
                    port_write_next      = pick.we;
                    port_read_next       = ~pick.we;
                    port_addr_next       = pick.addr;
                    port_write_data_next = pick.wdata;
                    state_next           = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (txn.we) begin
                    m0_ack_next = ~owner;
                    m1_ack_next = owner;
                    state_next  = ARB_DONE;
                end else begin
                    cnt_next   = CNT_W'(READ_LATENCY);
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    if (owner) begin
                        m1_rdata_next = port_read_data;
                    end else begin
                        m0_rdata_next = port_read_data;
                    end
                    m0_ack_next = ~owner;
                    m1_ack_next = owner;
                    state_next  = ARB_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ARB_DONE: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // State, latches and outputs; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ARB_IDLE;
            cnt             <= '0;
            txn             <= '0;
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            port_read       <= 1'b0;
            port_write      <= 1'b0;
            port_addr       <= '0;
            port_write_data <= '0;
            m0_ack          <= 1'b0;
            m1_ack          <= 1'b0;
            m0_rdata        <= '0;
            m1_rdata        <= '0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            txn             <= txn_next;
            owner           <= owner_next;
            last_grant      <= last_grant_next;
            port_read       <= port_read_next;
            port_write      <= port_write_next;
            port_addr       <= port_addr_next;
            port_write_data <= port_write_data_next;
            m0_ack          <= m0_ack_next;
            m1_ack          <= m1_ack_next;
            m0_rdata        <= m0_rdata_next;
            m1_rdata        <= m1_rdata_next;
        end
    end

endmodule
